// File: rtl/uart_parity_checker_pipe.sv
// Parity checker for the UART receive path with a 2-entry output FIFO,
// valid/ready handshakes on both sides and sticky/saturating error stats.
module uart_parity_checker_pipe #(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16,
    parameter bit DROP_BAD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clr
);
    localparam int ENT_W = DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENT_W-1:0] mem_q [2];
    logic [ENT_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             pop;
    logic             par;
    logic             fail;
    logic             push;
    logic [ENT_W-1:0] entry;

    // in_ready is purely registered; out_ready never reaches it
    assign in_ready  = (occ_q != 2'd2) && !rst;
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign par       = ^in_data;

    always_comb begin
        unique case (mode)
            2'b00:   fail = 1'b0;
            2'b10:   fail = !par;
            default: fail = par;
        endcase
    end

    assign push  = accept && !(fail && DROP_BAD);
    assign entry = fail ? {1'b1, {DATA_W{1'b0}}}
                        : {1'b0, in_data[DATA_W-1:0]};

    assign {out_perr, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (push) mem_d[wr_ptr_q] = entry;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // a failure in the same cycle as err_clr counts as the first new error
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (accept && fail) begin
            sticky_d = 1'b1;
            if (err_clr)            cnt_d = CNT_ONE;
            else if (cnt_q != '1)   cnt_d = cnt_q + CNT_ONE;
        end else if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_parity_checker_pipe.sv
// Bench for uart_parity_checker_pipe: three instances (default,
// DROP_BAD=1, CNT_W=2), directed scenarios plus random traffic vs a model.
module tb_uart_parity_checker_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] mode      [3];
    logic       in_valid  [3];
    logic       out_ready [3];
    logic       err_clr   [3];
    logic [8:0] in_data   [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_perr  [3];
    logic       err_sticky[3];
    logic [7:0] out_data  [3];
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_bad = 0;

    uart_parity_checker_pipe u_a (
        .clk(clk), .rst(rst), .mode(mode[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_perr(out_perr[0]), .err_sticky(err_sticky[0]),
        .err_count(cnt_a), .err_clr(err_clr[0])
    );

    uart_parity_checker_pipe #(.DROP_BAD(1'b1)) u_b (
        .clk(clk), .rst(rst), .mode(mode[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_perr(out_perr[1]), .err_sticky(err_sticky[1]),
        .err_count(cnt_b), .err_clr(err_clr[1])
    );

    uart_parity_checker_pipe #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .mode(mode[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_perr(out_perr[2]), .err_sticky(err_sticky[2]),
        .err_count(cnt_c), .err_clr(err_clr[2])
    );

    function automatic logic [15:0] cnt(int k);
        case (k)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return {14'd0, cnt_c};
        endcase
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            mode[k] = 2'd0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            err_clr[k] = 1'b0; in_data[k] = 9'd0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // drive one word and hold it until accepted (bounded wait)
    task automatic push(int k, logic [8:0] d, logic [1:0] m);
        int t = 0;
        @(negedge clk);
        mode[k] = m; in_data[k] = d; in_valid[k] = 1'b1;
        while (!in_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout inst=%0d in_ready stuck 0, need 1", k);
        end
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({in_ready[k], out_valid[k], out_data[k], out_perr[k],
                 err_sticky[k], cnt(k)} !== 28'd0) begin
                n_bad++;
                $display("FAIL reset_vals inst=%0d got rdy=%b v=%b d=%h p=%b s=%b c=%0d need all 0",
                         k, in_ready[k], out_valid[k], out_data[k],
                         out_perr[k], err_sticky[k], cnt(k));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release inst=%0d in_ready=%b need 1", k, in_ready[k]);
            end
        end
    endtask

    task automatic test_even();
        do_reset();
        out_ready[0] = 1'b1;
        push(0, 9'h0A3, 2'b01);
        n_cmp++;
        if ({out_valid[0], out_perr[0], out_data[0]} !== 10'h2A3) begin
            n_bad++;
            $display("FAIL even_pass got v=%b p=%b d=%h need 1/0/a3",
                     out_valid[0], out_perr[0], out_data[0]);
        end
        push(0, 9'h1A3, 2'b01);
        n_cmp++;
        if ({out_valid[0], out_perr[0], out_data[0]} !== 10'h300) begin
            n_bad++;
            $display("FAIL even_fail got v=%b p=%b d=%h need 1/1/00",
                     out_valid[0], out_perr[0], out_data[0]);
        end
        n_cmp++;
        if (cnt_a !== 16'd1 || err_sticky[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL even_stats got cnt=%0d sticky=%b need 1/1", cnt_a, err_sticky[0]);
        end
        // mode 11 behaves as even
        push(0, 9'h1A3, 2'b11);
        n_cmp++;
        if (out_perr[0] !== 1'b1 || cnt_a !== 16'd2) begin
            n_bad++;
            $display("FAIL mode11 got p=%b cnt=%0d need 1/2", out_perr[0], cnt_a);
        end
    endtask

    task automatic test_odd();
        do_reset();
        out_ready[0] = 1'b1;
        push(0, 9'h1A3, 2'b10);
        n_cmp++;
        if ({out_valid[0], out_perr[0], out_data[0]} !== 10'h2A3) begin
            n_bad++;
            $display("FAIL odd_pass got v=%b p=%b d=%h need 1/0/a3",
                     out_valid[0], out_perr[0], out_data[0]);
        end
        push(0, 9'h0A3, 2'b10);
        n_cmp++;
        if ({out_perr[0], out_data[0]} !== 9'h100 || cnt_a !== 16'd1) begin
            n_bad++;
            $display("FAIL odd_fail got p=%b d=%h cnt=%0d need 1/00/1",
                     out_perr[0], out_data[0], cnt_a);
        end
    endtask

    task automatic test_none();
        logic [8:0] w;
        int bad = 0;
        do_reset();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = 9'($urandom);
            push(0, w, 2'b00);
            n_cmp++;
            if ({out_valid[0], out_perr[0], out_data[0]} !== {2'b10, w[7:0]}) begin
                n_bad++;
                $display("FAIL none_word%0d got v=%b p=%b d=%h need 1/0/%h",
                         i, out_valid[0], out_perr[0], out_data[0], w[7:0]);
            end
        end
        n_cmp++;
        if (cnt_a !== 16'd0 || err_sticky[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL none_stats got cnt=%0d sticky=%b need 0/0", cnt_a, err_sticky[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w [3];
        do_reset();
        for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
        @(negedge clk);
        in_data[0] = {1'b1, w[0]}; in_valid[0] = 1'b1;
        @(negedge clk);
        in_data[0] = {1'b0, w[1]};
        @(negedge clk);
        in_data[0] = {1'b1, w[2]};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0] !== w[0]) begin
                n_bad++;
                $display("FAIL bp_full%0d got rdy=%b v=%b d=%h need 0/1/%h",
                         i, in_ready[0], out_valid[0], out_data[0], w[0]);
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) in_valid[0] = 1'b0;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== w[i]) begin
                n_bad++;
                $display("FAIL bp_order%0d got v=%b d=%h need 1/%h",
                         i, out_valid[0], out_data[0], w[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain got v=%b need 0", out_valid[0]);
        end
    endtask

    task automatic test_drop();
        do_reset();
        out_ready[1] = 1'b1;
        push(1, 9'h0A3, 2'b01);
        n_cmp++;
        if ({out_valid[1], out_perr[1], out_data[1]} !== 10'h2A3) begin
            n_bad++;
            $display("FAIL drop_w0 got v=%b p=%b d=%h need 1/0/a3",
                     out_valid[1], out_perr[1], out_data[1]);
        end
        push(1, 9'h1A3, 2'b01);
        n_cmp++;
        if (out_valid[1] !== 1'b0 || cnt_b !== 16'd1 || err_sticky[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_bad got v=%b cnt=%0d s=%b need 0/1/1",
                     out_valid[1], cnt_b, err_sticky[1]);
        end
        push(1, 9'h055, 2'b01);
        n_cmp++;
        if ({out_valid[1], out_perr[1], out_data[1]} !== 10'h255 || cnt_b !== 16'd1) begin
            n_bad++;
            $display("FAIL drop_w2 got v=%b p=%b d=%h cnt=%0d need 1/0/55/1",
                     out_valid[1], out_perr[1], out_data[1], cnt_b);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(2, 9'h1A3, 2'b01);
            n_cmp++;
            if (cnt_c !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                n_bad++;
                $display("FAIL sat_cnt%0d got %0d need %0d", i, cnt_c, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        err_clr[2] = 1'b1;
        push(2, 9'h1A3, 2'b01);
        err_clr[2] = 1'b0;
        n_cmp++;
        if (cnt_c !== 2'd1 || err_sticky[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_vs_err got cnt=%0d s=%b need 1/1", cnt_c, err_sticky[2]);
        end
        @(negedge clk);
        err_clr[2] = 1'b1;
        @(posedge clk);
        #1 err_clr[2] = 1'b0;
        n_cmp++;
        if (cnt_c !== 2'd0 || err_sticky[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_alone got cnt=%0d s=%b need 0/0", cnt_c, err_sticky[2]);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        push(2, 9'h1A3, 2'b01);
        push(2, 9'h0A3, 2'b01);
        n_cmp++;
        if (out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 || cnt_c !== 2'd1) begin
            n_bad++;
            $display("FAIL midop_pre got v=%b rdy=%b cnt=%0d need 1/0/1",
                     out_valid[2], in_ready[2], cnt_c);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid[2], out_data[2], out_perr[2], err_sticky[2], cnt_c} !== 13'd0) begin
            n_bad++;
            $display("FAIL midop_rst got v=%b d=%h p=%b s=%b cnt=%0d need all 0",
                     out_valid[2], out_data[2], out_perr[2], err_sticky[2], cnt_c);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random_traffic(int k, bit drop, int cmax);
        logic [8:0] q [$];
        int  ecnt = 0;
        bit  est  = 1'b0;
        bit  acc, pop, bad;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[k] !== (q.size() != 0) || in_ready[k] !== (q.size() < 2)) begin
                n_bad++;
                $display("FAIL rnd_flags inst=%0d cyc=%0d got v=%b rdy=%b need occ=%0d",
                         k, c, out_valid[k], in_ready[k], q.size());
            end
            if (q.size() != 0) begin
                n_cmp++;
                if ({out_perr[k], out_data[k]} !== q[0]) begin
                    n_bad++;
                    $display("FAIL rnd_head inst=%0d cyc=%0d got %h need %h",
                             k, c, {out_perr[k], out_data[k]}, q[0]);
                end
            end
            n_cmp++;
            if (cnt(k) !== 16'(ecnt) || err_sticky[k] !== est) begin
                n_bad++;
                $display("FAIL rnd_stats inst=%0d cyc=%0d got cnt=%0d s=%b need %0d/%b",
                         k, c, cnt(k), err_sticky[k], ecnt, est);
            end
            in_valid[k]  = $urandom_range(0, 3) != 0;
            out_ready[k] = $urandom_range(0, 2) != 0;
            mode[k]      = 2'($urandom_range(0, 3));
            in_data[k]   = 9'($urandom);
            err_clr[k]   = $urandom_range(0, 19) == 0;
            acc = in_valid[k] && (q.size() < 2);
            pop = (q.size() != 0) && out_ready[k];
            bad = acc && (mode[k] != 2'd0) &&
                  (($countones(in_data[k]) % 2) != ((mode[k] == 2'd2) ? 1 : 0));
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (acc && !(bad && drop))
                q.push_back(bad ? 9'h100 : {1'b0, in_data[k][7:0]});
            if (bad) begin
                est  = 1'b1;
                ecnt = err_clr[k] ? 1 : ((ecnt < cmax) ? ecnt + 1 : ecnt);
            end else if (err_clr[k]) begin
                est  = 1'b0;
                ecnt = 0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_even();
        test_odd();
        test_none();
        test_backpressure();
        test_drop();
        test_saturate();
        test_reset_midop();
        test_random_traffic(0, 1'b0, 65535);
        test_random_traffic(1, 1'b1, 65535);
        test_random_traffic(2, 1'b0, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_parity_checker_pipe.md
# uart_parity_checker_pipe

Parametrised, handshaked parity checker for the UART receive path. It sits between the receiver's deserialiser and the byte consumer. Each word is checked for even, odd or no parity, selected at run time. The block buffers up to two checked words under valid/ready back-pressure and keeps a sticky error flag and a saturating error counter.

## Interface
Parameters:
- DATA_W, 8, payload width; the input word carries DATA_W+1 bits with the parity bit as MSB
- CNT_W, 16, error counter width
- DROP_BAD, 0, 1: failing words are consumed and discarded; 0: failing words are forwarded with data forced to 0 and out_perr=1

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  00 none, 01 even, 10 odd, 11 treated as even
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word
- in_data  in  DATA_W+1  [DATA_W] parity bit, [DATA_W-1:0] payload
- out_valid  out  1  buffered word available
- out_ready  in  1  consumer takes the word
- out_data  out  DATA_W  checked payload
- out_perr  out  1  parity failure flag for the word on out_data
- err_sticky  out  1  set by any failing accepted word
- err_count  out  CNT_W  number of failing accepted words, saturating
- err_clr  in  1  synchronous clear of err_sticky and err_count

## Operation
- Accept when in_valid && in_ready at a rising edge. mode is sampled in that same cycle.
- Check: p = XOR of all DATA_W+1 bits of in_data.
  - even: pass iff p==0
  - odd: pass iff p==1
  - none: always pass; the parity bit is ignored
- Pass: push {perr=0, payload} into the 2-entry FIFO.
- Fail, DROP_BAD=0: push {perr=1, data=0}.
- Fail, DROP_BAD=1: no push. The word is still consumed (in_ready semantics unchanged).
- FIFO: 2 entries, 1-bit read/write pointers with wrap, occupancy 0..2, strict in-order delivery.
- Pop: out_valid && out_ready at an edge.
- out_valid = occupancy != 0. out_data and out_perr come from the head entry; both are 0 when empty.
- in_ready = (occupancy < 2) && !rst. It depends only on registered state; there is no combinational path from out_ready.
- Push and pop in the same cycle at occupancy 1: occupancy stays 1, both pointers advance.
- At occupancy 2, in_ready=0 even if out_ready=1. The pop frees a slot for the next cycle.
- Error stats: each accepted failing word (either DROP_BAD setting) sets err_sticky and increments err_count.
  - err_count holds at 2^CNT_W-1 once reached.
- err_clr alone: err_sticky=0, err_count=0 next cycle.
- err_clr together with an accepted failing word: the error wins, giving err_sticky=1 and err_count=1.
- Reset mid-operation: the FIFO is flushed and buffered words are lost. Stats are cleared.

## Timing
- Reset values: in_ready=0 while rst high, 1 on the first edge after release; out_valid=0, out_data=0, out_perr=0, err_sticky=0, err_count=0.
- Latency: a word accepted at edge t is visible on out_valid/out_data just after edge t, i.e. during cycle t+1, if the FIFO was empty.
- err_sticky and err_count update at the acceptance edge, so they are visible in the same cycle as the word's output.
- Throughput: one word per cycle when out_ready is held high.
- out_data and out_perr are stable while out_valid=1 and out_ready=0.

## Test plan
- mode=01, in_data=0x0A3 then 0x1A3, out_ready=1:
  - out 0xA3/perr 0
  - then 0x00/perr 1
  - err_count=1, err_sticky=1
- mode=10, in_data=0x1A3 -> 0xA3/perr 0. Then 0x0A3 -> perr 1.
- mode=00, random parity bits on 20 words -> all perr=0, err_count=0, data order preserved.
- out_ready=0, push 3 words:
  - the first two are accepted and in_ready drops
  - the third is held until one pop
  - output order w0, w1, w2
- DROP_BAD=1, mode=01, words 0x0A3, 0x1A3, 0x055 -> outputs 0xA3 then 0x55 only, err_count=1.
- CNT_W=2: feed 5 failing words -> err_count stays 3. err_clr in the same cycle as a 6th failure -> count 1. Assert rst with 2 words buffered -> out_valid=0 and counters 0 immediately.
